// File: rtl/modport_pkg.sv
// rtl/modport_pkg.sv - shared types and constants for the AHB-Lite to APB bridge
package modport_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WWAIT,
    S_WRITE,
    S_WENABLE,
    S_READ,
    S_RENABLE
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
  localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
  localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
  localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

endpackage

// File: rtl/modport_bridge_if.sv
// rtl/modport_bridge_if.sv - AHB-Lite slave side and APB master side of the bridge
interface modport_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        htrans;
  logic              hwrite;
  logic              hready_in;
  logic [2:0]        hsize;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic [1:0]        hresp;
  logic              hready_out;
  logic [DATA_W-1:0] prdata;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
  logic [2:0]        pselx;
  logic              penable;

  // The bridge itself: AHB slave facing the bus, driving the APB peripherals.
  modport slave (
    input  htrans, hwrite, hready_in, hsize, haddr, hwdata, prdata,
    output hrdata, hresp, hready_out, paddr, pwdata, pwrite, pselx, penable
  );

  // The surrounding system: AHB master plus APB peripherals.
  modport master (
    output htrans, hwrite, hready_in, hsize, haddr, hwdata, prdata,
    input  hrdata, hresp, hready_out, paddr, pwdata, pwrite, pselx, penable
  );
endinterface

// File: rtl/modport_decode.sv
// rtl/modport_decode.sv - range check and one-hot peripheral select from haddr
module modport_decode
  import modport_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] haddr,
  output logic              in_range,
  output logic [2:0]        sel
);

  assign sel[0] = (haddr >= ADDR_W'(REGION0_BASE)) && (haddr <= ADDR_W'(REGION0_LIMIT));
  assign sel[1] = (haddr >= ADDR_W'(REGION1_BASE)) && (haddr <= ADDR_W'(REGION1_LIMIT));
  assign sel[2] = (haddr >= ADDR_W'(REGION2_BASE)) && (haddr <= ADDR_W'(REGION2_LIMIT));

  assign in_range = |sel;

endmodule

// File: rtl/modport_bridge.sv
// rtl/modport_bridge.sv - AHB-Lite slave to APB master bridge, one APB setup/access per transfer
module modport_bridge
  import modport_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clock,
  input  logic             hreset,
  modport_bridge_if.slave  bus
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        sel_q;
  logic              write_q;

  logic       in_range;
  logic [2:0] sel;
  logic       valid;
  logic       accept;
  logic       ready;
  logic       psel_en;
  logic       access;
  logic       unused_hsize;

  assign unused_hsize = ^bus.hsize;

  modport_decode #(.ADDR_W(ADDR_W)) u_decode (
    .haddr    (bus.haddr),
    .in_range (in_range),
    .sel      (sel)
  );

  assign valid = bus.hready_in && in_range &&
                 ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));

  always_ff @(posedge clock) begin
    if (hreset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // accept marks the states where hready_out is high, i.e. an address phase can complete.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ready   = 1'b1;
    psel_en = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept = 1'b1;
      end
      S_WWAIT: begin
        ready   = 1'b0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ready   = 1'b0;
        psel_en = 1'b1;
        state_d = S_WENABLE;
      end
      S_WENABLE: begin
        psel_en = 1'b1;
        access  = 1'b1;
        accept  = 1'b1;
        state_d = S_IDLE;
      end
      S_READ: begin
        ready   = 1'b0;
        psel_en = 1'b1;
        state_d = S_RENABLE;
      end
      S_RENABLE: begin
        psel_en = 1'b1;
        access  = 1'b1;
        accept  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (accept && valid) begin
      state_d = bus.hwrite ? S_WWAIT : S_READ;
    end
  end

  // Address-phase registers update only on an accepted transfer, so they stay
  // stable across the following APB setup and access cycles.
  always_ff @(posedge clock) begin
    if (hreset) begin
      addr_q  <= '0;
      sel_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (accept && valid) begin
        addr_q  <= bus.haddr;
        sel_q   <= sel;
        write_q <= bus.hwrite;
      end
      if (state_q == S_WWAIT) begin
        wdata_q <= bus.hwdata;
      end
    end
  end

  assign bus.hready_out = ready;
  assign bus.hresp      = HRESP_OKAY;
  assign bus.hrdata     = (state_q == S_RENABLE) ? bus.prdata : '0;
  assign bus.paddr      = addr_q;
  assign bus.pwdata     = wdata_q;
  assign bus.pselx      = psel_en ? sel_q : 3'b000;
  assign bus.penable    = access;
  assign bus.pwrite     = psel_en && write_q;

endmodule

// File: tb/tb_modport_bridge.sv
// tb/tb_modport_bridge.sv - directed self-checking bench for modport_bridge
module tb_modport_bridge;
  import modport_pkg::*;

  logic clock = 1'b0;
  logic hreset;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  modport_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  modport_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock  (clock),
    .hreset (hreset),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.htrans = HTRANS_IDLE;
    bus.hwrite = 1'b0;
    bus.haddr  = 32'h0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".hready_out"}, 32'(bus.hready_out), 32'd1);
    chk({tag, ".hresp"},      32'(bus.hresp),      32'd0);
    chk({tag, ".hrdata"},     bus.hrdata,          32'h0);
    chk({tag, ".pselx"},      32'(bus.pselx),      32'd0);
    chk({tag, ".penable"},    32'(bus.penable),    32'd0);
    chk({tag, ".pwrite"},     32'(bus.pwrite),     32'd0);
    chk({tag, ".paddr"},      bus.paddr,           32'h0);
    chk({tag, ".pwdata"},     bus.pwdata,          32'h0);
  endtask

  // Single read; exp_sel = 0 means the transfer must be ignored.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [1:0] trans,
                         input logic rdy, input logic [2:0] exp_sel);
    bus.htrans    = trans;
    bus.hwrite    = 1'b0;
    bus.haddr     = addr;
    bus.hready_in = rdy;
    bus.prdata    = 32'hCAFE_0000 | addr[15:0];
    tick();
    idle_bus();
    bus.hready_in = 1'b1;
    chk({tag, ".pselx"}, 32'(bus.pselx), 32'(exp_sel));
    chk({tag, ".hready_out"}, 32'(bus.hready_out), (exp_sel == 3'b000) ? 32'd1 : 32'd0);
    if (exp_sel != 3'b000) begin
      tick();
      chk({tag, ".hrdata"}, bus.hrdata, 32'hCAFE_0000 | addr[15:0]);
    end
    tick();
  endtask

  task automatic do_write_ignored(input string tag, input logic [31:0] addr,
                                  input logic [1:0] trans, input logic rdy);
    bus.htrans    = trans;
    bus.hwrite    = 1'b1;
    bus.haddr     = addr;
    bus.hready_in = rdy;
    tick();
    idle_bus();
    bus.hready_in = 1'b1;
    chk({tag, ".hready_out"}, 32'(bus.hready_out), 32'd1);
    chk({tag, ".pselx"},      32'(bus.pselx),      32'd0);
    tick();
  endtask

  initial begin
    hreset        = 1'b1;
    bus.hready_in = 1'b1;
    bus.hsize     = 3'b010;
    bus.hwdata    = 32'h0;
    bus.prdata    = 32'h0;
    idle_bus();
    tick();
    tick();
    hreset = 1'b0;
    chk_reset_vals("reset");

    // Write 0xDEADBEEF to 0x8000_0010
    bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = 1'b1;
    bus.haddr  = 32'h8000_0010;
    tick();
    idle_bus();
    bus.hwdata = 32'hDEAD_BEEF;
    chk("wr.c1.hready_out", 32'(bus.hready_out), 32'd0);
    chk("wr.c1.pselx",      32'(bus.pselx),      32'd0);
    tick();
    bus.hwdata = 32'h0;
    chk("wr.c2.pselx",      32'(bus.pselx),      32'd1);
    chk("wr.c2.paddr",      bus.paddr,           32'h8000_0010);
    chk("wr.c2.pwdata",     bus.pwdata,          32'hDEAD_BEEF);
    chk("wr.c2.pwrite",     32'(bus.pwrite),     32'd1);
    chk("wr.c2.penable",    32'(bus.penable),    32'd0);
    chk("wr.c2.hready_out", 32'(bus.hready_out), 32'd0);
    tick();
    chk("wr.c3.penable",    32'(bus.penable),    32'd1);
    chk("wr.c3.hready_out", 32'(bus.hready_out), 32'd1);
    chk("wr.c3.pselx",      32'(bus.pselx),      32'd1);
    chk("wr.c3.pwdata",     bus.pwdata,          32'hDEAD_BEEF);
    tick();
    chk("wr.c4.pselx",      32'(bus.pselx),      32'd0);
    chk("wr.c4.penable",    32'(bus.penable),    32'd0);

    // Read 0x8400_0004
    bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = 1'b0;
    bus.haddr  = 32'h8400_0004;
    bus.prdata = 32'h1234_5678;
    tick();
    idle_bus();
    chk("rd.c1.pselx",      32'(bus.pselx),      32'd2);
    chk("rd.c1.penable",    32'(bus.penable),    32'd0);
    chk("rd.c1.pwrite",     32'(bus.pwrite),     32'd0);
    chk("rd.c1.hready_out", 32'(bus.hready_out), 32'd0);
    chk("rd.c1.hrdata",     bus.hrdata,          32'h0);
    chk("rd.c1.paddr",      bus.paddr,           32'h8400_0004);
    tick();
    chk("rd.c2.hrdata",     bus.hrdata,          32'h1234_5678);
    chk("rd.c2.hready_out", 32'(bus.hready_out), 32'd1);
    chk("rd.c2.penable",    32'(bus.penable),    32'd1);
    chk("rd.c2.hresp",      32'(bus.hresp),      32'd0);
    tick();
    chk("rd.c3.hrdata",     bus.hrdata,          32'h0);
    chk("rd.c3.pselx",      32'(bus.pselx),      32'd0);

    // Write 0x8800_0000 then SEQ read of 0x8000_0000 presented in WENABLE
    bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = 1'b1;
    bus.haddr  = 32'h8800_0000;
    tick();
    idle_bus();
    bus.hwdata = 32'hA5A5_5A5A;
    tick();
    chk("b2b.wsetup.pselx",  32'(bus.pselx),  32'd4);
    chk("b2b.wsetup.pwdata", bus.pwdata,      32'hA5A5_5A5A);
    tick();
    chk("b2b.wenable.pselx",   32'(bus.pselx),   32'd4);
    chk("b2b.wenable.penable", 32'(bus.penable), 32'd1);
    bus.htrans = HTRANS_SEQ;
    bus.hwrite = 1'b0;
    bus.haddr  = 32'h8000_0000;
    bus.prdata = 32'h0BAD_F00D;
    tick();
    idle_bus();
    chk("b2b.rsetup.pselx",   32'(bus.pselx),   32'd1);
    chk("b2b.rsetup.penable", 32'(bus.penable), 32'd0);
    chk("b2b.rsetup.pwrite",  32'(bus.pwrite),  32'd0);
    chk("b2b.rsetup.paddr",   bus.paddr,        32'h8000_0000);
    tick();
    chk("b2b.renable.hrdata", bus.hrdata,       32'h0BAD_F00D);
    tick();
    chk("b2b.end.pselx",      32'(bus.pselx),   32'd0);

    // Ignored transfers
    do_write_ignored("ign.idle",    32'h8000_0000, HTRANS_IDLE,   1'b1);
    do_write_ignored("ign.busy",    32'h8000_0000, HTRANS_BUSY,   1'b1);
    do_write_ignored("ign.range",   32'h9000_0000, HTRANS_NONSEQ, 1'b1);
    do_write_ignored("ign.notrdy",  32'h8000_0000, HTRANS_NONSEQ, 1'b0);
    do_read("ign.rd_range_lo",      32'h7FFF_FFFC, HTRANS_NONSEQ, 1'b1, 3'b000);
    do_read("ign.rd_range_hi",      32'h8C00_0000, HTRANS_NONSEQ, 1'b1, 3'b000);

    // Region boundaries
    do_read("bnd.r0_top", 32'h83FF_FFFC, HTRANS_NONSEQ, 1'b1, 3'b001);
    do_read("bnd.r1_bot", 32'h8400_0000, HTRANS_NONSEQ, 1'b1, 3'b010);
    do_read("bnd.r1_top", 32'h87FF_FFFC, HTRANS_SEQ,    1'b1, 3'b010);
    do_read("bnd.r2_top", 32'h8BFF_FFFC, HTRANS_NONSEQ, 1'b1, 3'b100);

    // Reset during WRITE
    bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = 1'b1;
    bus.haddr  = 32'h8400_0008;
    tick();
    idle_bus();
    bus.hwdata = 32'h5555_AAAA;
    tick();
    chk("rst.write.pselx", 32'(bus.pselx), 32'd2);
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    chk_reset_vals("rst.after");
    tick();
    chk("rst.nopulse.penable", 32'(bus.penable), 32'd0);
    chk("rst.nopulse.pselx",   32'(bus.pselx),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
